// File: rtl/wf_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wf_view_ctrl
// Brief    : Waveform view window controller; zoom/pan requests are applied
//            to the x/y window limits only on a display frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module wf_view_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_zoom_in,
    input  logic       btn_zoom_out,
    input  logic       btn_pan_left,
    input  logic       btn_pan_right,
    input  logic       frame_tick,
    output logic [9:0] start_x,
    output logic [9:0] end_x,
    output logic [9:0] start_y,
    output logic [9:0] end_y,
    output logic       busy,
    output logic       update
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CALC    = 2'd1;
    localparam logic [1:0] c_WAIT    = 2'd2;

    localparam logic [1:0] c_OP_ZIN  = 2'd0;
    localparam logic [1:0] c_OP_ZOUT = 2'd1;
    localparam logic [1:0] c_OP_PL   = 2'd2;
    localparam logic [1:0] c_OP_PR   = 2'd3;

    localparam logic [9:0] c_X_MAX   = 10'd640;
    localparam logic [9:0] c_X_MID   = 10'd320;
    localparam logic [9:0] c_Y_MID   = 10'd240;
    localparam logic [9:0] c_PAN_Z0  = 10'd160;

    logic [1:0] r_state;
    logic [1:0] r_z;
    logic [9:0] r_cx;
    logic       r_pend_vld;
    logic [1:0] r_pend_op;
    logic [1:0] r_op;
    logic [1:0] r_sh_z;
    logic [9:0] r_sh_cx;
    logic [9:0] r_sh_sx, r_sh_ex, r_sh_sy, r_sh_ey;

    logic       w_btn_any;
    logic [1:0] w_btn_op;
    logic       w_sel_vld;
    logic [1:0] w_sel_op;
    logic [9:0] w_cur_hw;
    logic       w_noop;
    logic [1:0] w_nz;
    logic [9:0] w_step;
    logic [9:0] w_cx_raw;
    logic [9:0] w_new_hw;
    logic [9:0] w_new_hh;
    logic [9:0] w_new_cx;

    assign busy = (r_state != c_IDLE);

    always_comb begin
        w_btn_any = btn_zoom_in | btn_zoom_out | btn_pan_left | btn_pan_right;
        if (btn_zoom_in)       w_btn_op = c_OP_ZIN;
        else if (btn_zoom_out) w_btn_op = c_OP_ZOUT;
        else if (btn_pan_left) w_btn_op = c_OP_PL;
        else                   w_btn_op = c_OP_PR;
    end

    // A held pending request always wins over a fresh press in IDLE.
    assign w_sel_vld = r_pend_vld | w_btn_any;
    assign w_sel_op  = r_pend_vld ? r_pend_op : w_btn_op;
    assign w_cur_hw  = c_X_MID >> r_z;

    always_comb begin
        w_noop = 1'b0;
        case (w_sel_op)
            c_OP_ZIN:  w_noop = (r_z == 2'd3);
            c_OP_ZOUT: w_noop = (r_z == 2'd0);
            c_OP_PL:   w_noop = (r_cx <= w_cur_hw);
            default:   w_noop = (r_cx >= (c_X_MAX - w_cur_hw));
        endcase
    end

    always_comb begin
        w_nz     = r_z;
        w_step   = c_PAN_Z0 >> r_z;
        w_cx_raw = r_cx;
        case (r_op)
            c_OP_ZIN:  w_nz     = r_z + 2'd1;
            c_OP_ZOUT: w_nz     = r_z - 2'd1;
            c_OP_PL:   w_cx_raw = r_cx - w_step;
            default:   w_cx_raw = r_cx + w_step;
        endcase
        w_new_hw = c_X_MID >> w_nz;
        w_new_hh = c_Y_MID >> w_nz;
        if (w_cx_raw < w_new_hw)
            w_new_cx = w_new_hw;
        else if (w_cx_raw > (c_X_MAX - w_new_hw))
            w_new_cx = c_X_MAX - w_new_hw;
        else
            w_new_cx = w_cx_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_z        <= 2'd0;
            r_cx       <= c_X_MID;
            r_pend_vld <= 1'b0;
            r_pend_op  <= 2'd0;
            r_op       <= 2'd0;
            r_sh_z     <= 2'd0;
            r_sh_cx    <= c_X_MID;
            r_sh_sx    <= 10'd0;
            r_sh_ex    <= 10'd639;
            r_sh_sy    <= 10'd0;
            r_sh_ey    <= 10'd479;
            start_x    <= 10'd0;
            end_x      <= 10'd639;
            start_y    <= 10'd0;
            end_y      <= 10'd479;
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // Consuming the pending slot frees it for this cycle's press.
                    if (r_pend_vld) begin
                        r_pend_vld <= w_btn_any;
                        r_pend_op  <= w_btn_op;
                    end
                    if (w_sel_vld && !w_noop) begin
                        r_op    <= w_sel_op;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    if (!r_pend_vld && w_btn_any) begin
                        r_pend_vld <= 1'b1;
                        r_pend_op  <= w_btn_op;
                    end
                    r_sh_z  <= w_nz;
                    r_sh_cx <= w_new_cx;
                    r_sh_sx <= w_new_cx - w_new_hw;
                    r_sh_ex <= w_new_cx + w_new_hw - 10'd1;
                    r_sh_sy <= c_Y_MID - w_new_hh;
                    r_sh_ey <= c_Y_MID + w_new_hh - 10'd1;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (!r_pend_vld && w_btn_any) begin
                        r_pend_vld <= 1'b1;
                        r_pend_op  <= w_btn_op;
                    end
                    if (frame_tick) begin
                        r_z     <= r_sh_z;
                        r_cx    <= r_sh_cx;
                        start_x <= r_sh_sx;
                        end_x   <= r_sh_ex;
                        start_y <= r_sh_sy;
                        end_y   <= r_sh_ey;
                        update  <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wf_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wf_view_ctrl
// Brief    : Self-checking bench for wf_view_ctrl: directed vector table,
//            abort sequence and randomized run against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wf_view_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_zoom_in, btn_zoom_out, btn_pan_left, btn_pan_right;
    logic       frame_tick;
    logic [9:0] start_x, end_x, start_y, end_y;
    logic       busy, update;

    always #5 clk = ~clk;

    wf_view_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .btn_zoom_in  (btn_zoom_in),
        .btn_zoom_out (btn_zoom_out),
        .btn_pan_left (btn_pan_left),
        .btn_pan_right(btn_pan_right),
        .frame_tick   (frame_tick),
        .start_x      (start_x),
        .end_x        (end_x),
        .start_y      (start_y),
        .end_y        (end_y),
        .busy         (busy),
        .update       (update)
    );

    typedef struct {
        logic r, zi, zo, pl, pr, ft;
        int   sx, ex, sy, ey;
        logic b, u;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Transaction-level reference: committed zoom/centre, one in-flight op
    // with its age in cycles, and a single pending slot (-1 = empty).
    int m_z, m_cx, m_pend, m_op, m_age;
    bit m_inflight, m_upd;

    function automatic vec_t mk(input logic r, zi, zo, pl, pr, ft,
                                input int sx, ex, sy, ey, input logic b, u);
        vec_t v;
        v.r = r; v.zi = zi; v.zo = zo; v.pl = pl; v.pr = pr; v.ft = ft;
        v.sx = sx; v.ex = ex; v.sy = sy; v.ey = ey; v.b = b; v.u = u;
        return v;
    endfunction

    function automatic void apply_op(input int op, input int z, input int cx,
                                     output int nz, output int ncx);
        int w, hw;
        w   = 640 >> z;
        nz  = z;
        ncx = cx;
        case (op)
            0: if (z < 3) nz = z + 1;
            1: if (z > 0) nz = z - 1;
            2: ncx = cx - w / 4;
            default: ncx = cx + w / 4;
        endcase
        hw = (640 >> nz) / 2;
        if (ncx < hw) ncx = hw;
        if (ncx > 640 - hw) ncx = 640 - hw;
    endfunction

    task automatic model_step(input logic r, zi, zo, pl, pr, ft);
        int press, sel, nz, ncx;
        if (!r) begin
            m_z = 0; m_cx = 320; m_pend = -1; m_op = 0; m_age = 0;
            m_inflight = 0; m_upd = 0;
        end else begin
            press = zi ? 0 : zo ? 1 : pl ? 2 : pr ? 3 : -1;
            m_upd = 0;
            if (!m_inflight) begin
                sel = (m_pend >= 0) ? m_pend : press;
                if (m_pend >= 0) m_pend = press;
                if (sel >= 0) begin
                    apply_op(sel, m_z, m_cx, nz, ncx);
                    if (nz != m_z || ncx != m_cx) begin
                        m_inflight = 1; m_age = 0; m_op = sel;
                    end
                end
            end else begin
                if (m_pend < 0) m_pend = press;
                if (m_age >= 1 && ft) begin
                    apply_op(m_op, m_z, m_cx, nz, ncx);
                    m_z = nz; m_cx = ncx; m_upd = 1; m_inflight = 0;
                end
                m_age++;
            end
        end
    endtask

    task automatic check(input string name, input int idx,
                         input int sx, ex, sy, ey, input logic b, u);
        n_tests++;
        if (int'(start_x) != sx || int'(end_x) != ex || int'(start_y) != sy ||
            int'(end_y) != ey || busy !== b || update !== u) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d/%0d/%0d/%0d busy=%0b upd=%0b, want %0d/%0d/%0d/%0d busy=%0b upd=%0b",
                     name, idx, start_x, end_x, start_y, end_y, busy, update,
                     sx, ex, sy, ey, b, u);
        end
    endtask

    task automatic check_model(input string name, input int idx);
        int hw, hh;
        hw = (640 >> m_z) / 2;
        hh = (480 >> m_z) / 2;
        check(name, idx, m_cx - hw, m_cx + hw - 1, 240 - hh, 240 + hh - 1,
              m_inflight, m_upd);
    endtask

    task automatic step(input logic r, zi, zo, pl, pr, ft);
        rst = r; btn_zoom_in = zi; btn_zoom_out = zo;
        btn_pan_left = pl; btn_pan_right = pr; frame_tick = ft;
        @(posedge clk);
        model_step(r, zi, zo, pl, pr, ft);
        #1;
    endtask

    initial begin
        rst = 0; btn_zoom_in = 0; btn_zoom_out = 0;
        btn_pan_left = 0; btn_pan_right = 0; frame_tick = 0;

        //              r  zi zo pl pr ft   sx   ex   sy   ey  b  u
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 639,   0, 479, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 639,   0, 479, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 0, 0));
        // zoom in, tick five cycles after the press
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 160, 479, 120, 359, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 160, 479, 120, 359, 0, 0));
        // second zoom in; tick during CALC is ignored
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 240, 399, 180, 299, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 240, 399, 180, 299, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 240, 399, 180, 299, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 280, 359, 210, 269, 0, 1));
        // zoom in at z=3 is discarded
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 280, 359, 210, 269, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 280, 359, 210, 269, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 280, 359, 210, 269, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 280, 359, 210, 269, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 240, 399, 180, 299, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 240, 399, 180, 299, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 240, 399, 180, 299, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 160, 479, 120, 359, 0, 1));
        // pans at z=1
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 240, 559, 120, 359, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 240, 559, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 240, 559, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 320, 639, 120, 359, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 320, 639, 120, 359, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 320, 639, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 320, 639, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 639,   0, 479, 0, 1));
        // simultaneous zoom_in + pan_right: only the zoom applies
        vecs.push_back(mk(1, 1, 0, 0, 1, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 160, 479, 120, 359, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 160, 479, 120, 359, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 639,   0, 479, 0, 1));
        // pans at z=0 are discarded
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   0, 639,   0, 479, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   0, 639,   0, 479, 0, 0));
        // pending: second zoom_in kept, third dropped
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 639,   0, 479, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 160, 479, 120, 359, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 160, 479, 120, 359, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 240, 399, 180, 299, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 240, 399, 180, 299, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 240, 399, 180, 299, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].zi, vecs[i].zo, vecs[i].pl, vecs[i].pr, vecs[i].ft);
            check("vec", i, vecs[i].sx, vecs[i].ex, vecs[i].sy, vecs[i].ey,
                  vecs[i].b, vecs[i].u);
            check_model("vec_model", i);
        end

        // Abort: reset coincides with frame_tick while waiting
        step(1, 0, 1, 0, 0, 0);
        check("abort_calc", 0, 240, 399, 180, 299, 1'b1, 1'b0);
        step(1, 0, 0, 0, 0, 0);
        check("abort_wait", 0, 240, 399, 180, 299, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 1);
        check("abort_rst", 0, 0, 639, 0, 479, 1'b0, 1'b0);
        step(1, 0, 0, 0, 0, 1);
        check("abort_after", 0, 0, 639, 0, 479, 1'b0, 1'b0);
        check_model("abort_model", 0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            logic r, zi, zo, pl, pr, ft;
            r  = ($urandom_range(0, 199) != 0);
            zi = ($urandom_range(0, 9) == 0);
            zo = ($urandom_range(0, 9) == 0);
            pl = ($urandom_range(0, 5) == 0);
            pr = ($urandom_range(0, 5) == 0);
            ft = ($urandom_range(0, 3) == 0);
            step(r, zi, zo, pl, pr, ft);
            check_model("rand", k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wf_view_ctrl.md
WF_VIEW_CTRL -- requirements
Module: wf_view_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-low (rst=0 at a rising edge resets the block).
REQ-003 SHALL have port: btn_zoom_in  input  1  one-cycle request pulse, zoom in one level.
REQ-004 SHALL have port: btn_zoom_out  input  1  one-cycle request pulse, zoom out one level.
REQ-005 SHALL have port: btn_pan_left  input  1  one-cycle request pulse, move the x window centre left.
REQ-006 SHALL have port: btn_pan_right  input  1  one-cycle request pulse, move the x window centre right.
REQ-007 SHALL have port: frame_tick  input  1  one-cycle pulse at the display frame boundary.
REQ-008 SHALL have ports: start_x, end_x, start_y, end_y  output  10 each  registered waveform window limits, inclusive pixel coordinates.
REQ-009 SHALL have port: busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port: update  output  1  high for exactly one cycle after the limits change.

Function
REQ-011 SHALL hold a zoom level z in 0..3 (2 bits) and an x centre cx (10 bits); W=640>>z; H=480>>z.
REQ-012 SHALL derive the limits as follows: start_x=cx-W/2, end_x=cx+W/2-1, start_y=240-H/2, end_y=240+H/2-1; all values SHALL stay in range with no wrap-around.
REQ-013 SHALL keep cx within [W/2, 640-W/2] after every operation by clamping to the nearer bound.
REQ-014 SHALL implement a 3-state FSM: IDLE, CALC, WAIT.
REQ-015 SHALL select one request in IDLE: the pending request if one is held, otherwise the highest-priority asserted button. Priority order: zoom_in > zoom_out > pan_left > pan_right. Lower-priority buttons asserted in the same cycle SHALL be dropped.
REQ-016 SHALL discard a selected request that produces no change, with no state transition and no update pulse. Cases: zoom_in at z=3; zoom_out at z=0; a pan when cx is already at the bound in that direction, including any pan at z=0.
REQ-017 SHALL move IDLE->CALC for a non-discarded request. In CALC, shadow z/cx and shadow limits SHALL be computed: zoom changes z by ±1, keeps cx, then clamps; a pan moves cx by W/4 (W at the current z), then clamps.
REQ-018 SHALL go CALC->WAIT unconditionally after one cycle; a frame_tick that arrives during CALC SHALL be ignored.
REQ-019 SHALL, in WAIT with frame_tick=1, load the shadow values into z, cx and the four outputs, set update=1 for the next cycle only, and return to IDLE. The limits SHALL therefore change only on a frame boundary.
REQ-020 SHALL latch a button press that arrives in CALC or WAIT into a one-deep pending register, using the REQ-015 priority, if that register is empty. Presses while the register is full SHALL be dropped.
REQ-021 SHALL evaluate a pending request against the committed z/cx at the moment it is selected in IDLE. When a pending request is consumed in IDLE and a button is pressed in the same cycle, that press SHALL become the new pending request.
REQ-022 SHALL have a latency from request in IDLE (cycle N) to limits updated of at least N+3: CALC at N+1, WAIT from N+2, update when frame_tick is sampled in WAIT.

Reset
REQ-023 SHALL apply the following on rst=0 at a rising edge: state=IDLE, z=0, cx=320, start_x=0, end_x=639, start_y=0, end_y=479, busy=0, update=0, pending cleared, shadow registers discarded.
REQ-024 SHALL treat reset arriving in CALC or WAIT as an abort: no update pulse and no partial limit change, regardless of frame_tick in the same cycle.

Verification
REQ-025 Reset check: hold rst=0 for 2 cycles, then release -> limits 0/639/0/479, busy=0, update=0.
REQ-026 Zoom-in check: pulse zoom_in, then frame_tick 5 cycles later -> busy=1 until the tick, limits 160/479/120/359, update high for 1 cycle. Apply three zoom_in requests in total -> 280/359/210/269. A fourth zoom_in -> discarded, busy stays 0.
REQ-027 Pan check: at z=1, pan_right applied -> 240/559. Second pan_right -> 320/639. Third pan_right -> discarded. Then zoom_out -> cx clamped to 320, limits 0/639/0/479.
REQ-028 Priority and discard check: zoom_in and pan_right asserted in the same cycle at z=0 -> only the zoom is applied (160/479). pan_left at z=0 -> no busy, no update.
REQ-029 Pending check: zoom_in, then zoom_in during WAIT, then another zoom_in also during WAIT (dropped), then two frame_ticks -> z=2, limits 240/399/180/299, and exactly two update pulses.
REQ-030 Abort check: reset asserted in WAIT in the same cycle as frame_tick -> limits 0/639/0/479, no update pulse.
